// File: rtl/bcd_pkg.sv
// Shared definitions for the seven-segment scan path: blank pattern,
// scan FSM states and the prescaler minimum.
package bcd_pkg;

    localparam logic [6:0] BLANK_SEG   = 7'b1111111;
    localparam int         CLK_DIV_MIN = 2;
    localparam int         NDIG_MIN    = 2;
    localparam int         NDIG_MAX    = 8;

    typedef enum logic {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // A dwell needs at least one SHOW cycle besides the guard cycle.
    function automatic bit clk_div_ok(input int clk_div);
        return clk_div >= CLK_DIV_MIN;
    endfunction

    function automatic bit ndig_ok(input int ndig);
        return (ndig >= NDIG_MIN) && (ndig <= NDIG_MAX);
    endfunction

endpackage

// File: rtl/decoder_segments.sv
// Hex nibble to seven-segment pattern, segments ordered {a..g}, active-low.
module decoder_segments (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (hex)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode seven-segment display with a
// one-cycle guard between digits and frame-aligned commit of new content.
module seg_scan_ctrl
    import bcd_pkg::*;
#(
    parameter int NDIG    = 4,
    parameter int CLK_DIV = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_stb,
    input  logic [4*NDIG-1:0]   wr_data,
    input  logic [NDIG-1:0]     wr_blank,
    output logic                wr_busy,
    output logic                wr_ack,
    output logic [NDIG-1:0]     an,
    output logic [6:0]          sseg,
    output logic                frame_tick
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (!clk_div_ok(CLK_DIV)) begin : g_bad_clk_div
        $error("seg_scan_ctrl: CLK_DIV below minimum");
    end
    if (!ndig_ok(NDIG)) begin : g_bad_ndig
        $error("seg_scan_ctrl: NDIG out of range");
    end

    logic [DIV_W-1:0]       div;
    logic [IDX_W-1:0]       idx;
    scan_state_t            state;

    logic [NDIG-1:0][3:0]   disp;
    logic [NDIG-1:0]        disp_blank;
    logic [NDIG-1:0][3:0]   pend;
    logic [NDIG-1:0]        pend_blank;

    logic                   tc;
    logic                   last_digit;
    logic                   boundary;
    logic [3:0]             cur_nibble;
    logic [6:0]             cur_seg;
    logic [6:0]             show_seg;
    logic [NDIG-1:0]        show_an;

    assign tc         = (div == DIV_W'(CLK_DIV - 1));
    assign last_digit = (idx == IDX_W'(NDIG - 1));
    assign boundary   = tc && last_digit;

    // Single shared decoder, steered by the current digit index.
    assign cur_nibble = disp[idx];

    decoder_segments u_decoder (
        .hex (cur_nibble),
        .seg (cur_seg)
    );

    assign show_seg = disp_blank[idx] ? BLANK_SEG : cur_seg;
    assign show_an  = ~(NDIG'(1) << idx);

    // Prescaler, digit index and the GUARD/SHOW scan FSM with registered pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div        <= '0;
            idx        <= '0;
            state      <= GUARD;
            an         <= '1;
            sseg       <= BLANK_SEG;
            frame_tick <= 1'b0;
        end else begin
            div        <= tc ? '0 : div + DIV_W'(1);
            frame_tick <= boundary;
            if (tc) begin
                idx <= last_digit ? '0 : idx + IDX_W'(1);
            end
            case (state)
                GUARD: begin
                    state <= SHOW;
                    an    <= show_an;
                    sseg  <= show_seg;
                end
                SHOW: begin
                    if (tc) begin
                        state <= GUARD;
                        an    <= '1;
                        sseg  <= BLANK_SEG;
                    end else begin
                        state <= SHOW;
                        an    <= show_an;
                        sseg  <= show_seg;
                    end
                end
                default: begin
                    state <= GUARD;
                    an    <= '1;
                    sseg  <= BLANK_SEG;
                end
            endcase
        end
    end

    // Bus side: valid/ready style where wr_busy low means a strobe is taken.
    // A strobe seen while busy (including the commit cycle) is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp       <= '0;
            disp_blank <= '1;
            pend       <= '0;
            pend_blank <= '0;
            wr_busy    <= 1'b0;
            wr_ack     <= 1'b0;
        end else begin
            wr_ack <= 1'b0;
            if (wr_busy && boundary) begin
                disp       <= pend;
                disp_blank <= pend_blank;
                wr_busy    <= 1'b0;
                wr_ack     <= 1'b1;
            end else if (wr_stb && !wr_busy) begin
                pend       <= wr_data;
                pend_blank <= wr_blank;
                wr_busy    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: random writes against a frame-arithmetic model,
// expected commits queued by the driver and checked by a per-cycle monitor.
module tb_seg_scan_ctrl;

    localparam int NDIG    = 4;
    localparam int CLK_DIV = 4;
    localparam int FRAME   = NDIG * CLK_DIV;

    logic                clk;
    logic                reset;
    logic                wr_stb;
    logic [4*NDIG-1:0]   wr_data;
    logic [NDIG-1:0]     wr_blank;
    logic                wr_busy;
    logic                wr_ack;
    logic [NDIG-1:0]     an;
    logic [6:0]          sseg;
    logic                frame_tick;

    seg_scan_ctrl #(
        .NDIG    (NDIG),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_stb     (wr_stb),
        .wr_data    (wr_data),
        .wr_blank   (wr_blank),
        .wr_busy    (wr_busy),
        .wr_ack     (wr_ack),
        .an         (an),
        .sseg       (sseg),
        .frame_tick (frame_tick)
    );

    // ---------------- clock / reset / edge counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // k = number of active edges since reset release.
    int unsigned k;
    always @(posedge clk) begin
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [31:0]       cap;
        logic [31:0]       commit;
        logic [4*NDIG-1:0] data;
        logic [NDIG-1:0]   blank;
    } wr_exp_t;

    wr_exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic              pend_valid;
    int unsigned       pend_commit;
    logic [4*NDIG-1:0] cur_data;
    logic [NDIG-1:0]   cur_blank;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", name, act, exp, k, $time);
        end
    endtask

    function automatic logic [6:0] hex_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [NDIG-1:0] e_an;
        logic [6:0]      e_sseg;
        logic            e_ack;
        logic            e_busy;
        logic            e_tick;
        int              d;
        if (reset) begin
            cur_data  = '0;
            cur_blank = '1;
            chk("rst_an",   32'(an),         32'hF);
            chk("rst_sseg", 32'(sseg),       32'h7F);
            chk("rst_busy", 32'(wr_busy),    32'h0);
            chk("rst_ack",  32'(wr_ack),     32'h0);
            chk("rst_tick", 32'(frame_tick), 32'h0);
        end else begin
            e_ack = (exp_q.size() > 0) && (exp_q[0].commit == k);
            if (e_ack) begin
                cur_data  = exp_q[0].data;
                cur_blank = exp_q[0].blank;
                void'(exp_q.pop_front());
            end
            e_busy = (exp_q.size() > 0) && (exp_q[0].cap <= k);
            e_tick = (k != 0) && (k % FRAME == 0);
            if (k % CLK_DIV == 0) begin
                e_an   = '1;
                e_sseg = 7'h7F;
            end else begin
                d      = (k / CLK_DIV) % NDIG;
                e_an   = ~(NDIG'(1) << d);
                e_sseg = cur_blank[d] ? 7'h7F : hex_seg(cur_data[4*d +: 4]);
            end
            chk("an",         32'(an),         32'(e_an));
            chk("sseg",       32'(sseg),       32'(e_sseg));
            chk("wr_ack",     32'(wr_ack),     32'(e_ack));
            chk("wr_busy",    32'(wr_busy),    32'(e_busy));
            chk("frame_tick", 32'(frame_tick), 32'(e_tick));
        end
    end

    // ---------------- driver tasks ----------------
    // All stimulus lives 2 time units after an active edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_write(input logic [4*NDIG-1:0] data, input logic [NDIG-1:0] blank);
        int unsigned e;
        wr_exp_t     ent;
        e = k + 1;
        if (pend_valid && pend_commit < e) pend_valid = 1'b0;
        if (!pend_valid) begin
            pend_valid  = 1'b1;
            pend_commit = (e / FRAME + 1) * FRAME;
            ent.cap     = e;
            ent.commit  = pend_commit;
            ent.data    = data;
            ent.blank   = blank;
            exp_q.push_back(ent);
        end
        wr_stb   = 1'b1;
        wr_data  = data;
        wr_blank = blank;
        step();
        wr_stb   = 1'b0;
        wr_data  = $urandom;
        wr_blank = NDIG'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            if (!pend_valid || pend_commit <= k) break;
            step();
        end
    endtask

    task automatic wait_phase(input int unsigned ph);
        for (int i = 0; i < FRAME + 1; i++) begin
            if (k % FRAME == ph) break;
            step();
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        exp_q.delete();
        pend_valid = 1'b0;
        step_n(cycles);
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset       = 1'b1;
        wr_stb      = 1'b0;
        wr_data     = '0;
        wr_blank    = '0;
        pend_valid  = 1'b0;
        pend_commit = 0;
        cur_data    = '0;
        cur_blank   = '1;
        step_n(3);
        reset = 1'b0;

        // First frame dark, then a mid-frame write and a dropped second write.
        step_n(FRAME + 5);
        do_write(16'h12AF, 4'b0000);
        step_n(2);
        do_write(16'h0000, 4'b0000);
        wait_idle();
        step_n(FRAME + 2);

        do_write(16'h8888, 4'b1010);
        wait_idle();
        step_n(FRAME + 2);

        // Strobe exactly in the frame-boundary cycle while idle.
        wait_phase(FRAME - 1);
        do_write(16'h3C5E, 4'b0001);
        // Strobe in the commit cycle itself, while still busy: dropped.
        wait_phase(FRAME - 1);
        do_write(16'h9999, 4'b0000);
        wait_idle();
        step_n(FRAME + 1);

        for (int n = 0; n < 40; n++) begin
            step_n($urandom_range(0, 24));
            do_write(16'($urandom), NDIG'($urandom_range(0, (1 << NDIG) - 1)));
        end
        wait_idle();
        step_n(FRAME);

        // Reset while a write is pending and digit 2 is on.
        wait_phase(1);
        do_write(16'hBEEF, 4'b0000);
        for (int i = 0; i < FRAME; i++) begin
            if ((k / CLK_DIV) % NDIG == 2 && k % CLK_DIV != 0) break;
            step();
        end
        chk("busy_before_reset", 32'(wr_busy), 32'h1);
        do_reset(2);
        step_n(3 * FRAME);

        wait_idle();
        step_n(2);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
